// File: rtl/wb_write_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : wb_write_arbiter_if
//  Description : Bundle for the regfile writeback arbiter. It carries the
//                pipeline and multdiv write sources, the regfile write port
//                and the pending-register status.
//  Revision    : 1.0 - initial release
// ============================================================================
interface wb_write_arbiter_if #(
    parameter int CNTW = 2
);
    // MW-stage pipeline writeback
    logic              pipe_valid;
    logic [4:0]        pipe_reg;
    logic [31:0]       pipe_data;
    // Multdiv result handshake
    logic              md_valid;
    logic              md_ready;
    logic [4:0]        md_reg;
    logic [31:0]       md_data;
    // Regfile write port
    logic              ctrl_writeEnable;
    logic [4:0]        ctrl_writeReg;
    logic [31:0]       data_writeReg;
    // Status for the hazard/stall unit
    logic [31:0]       md_pending_mask;
    logic [CNTW:0]     md_count;

    // Source side: drives both writeback sources, observes the regfile port
    modport master (
        output pipe_valid, pipe_reg, pipe_data,
        output md_valid, md_reg, md_data,
        input  md_ready,
        input  ctrl_writeEnable, ctrl_writeReg, data_writeReg,
        input  md_pending_mask, md_count
    );

    // Arbiter side
    modport slave (
        input  pipe_valid, pipe_reg, pipe_data,
        input  md_valid, md_reg, md_data,
        output md_ready,
        output ctrl_writeEnable, ctrl_writeReg, data_writeReg,
        output md_pending_mask, md_count
    );
endinterface
`default_nettype wire

// File: rtl/wb_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : wb_write_arbiter
//  Description : Owns the regfile write port. Pipeline writes always win;
//                multdiv results are bypassed when the port and buffer are
//                free, otherwise held in a small FIFO until an idle cycle.
//                A pipeline write squashes older buffered results to the
//                same register (WAW).
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_write_arbiter #(
    parameter int DEPTH = 2,
    parameter int CNTW  = 2
) (
    input  wire logic           clock,
    input  wire logic           ctrl_reset,
    wb_write_arbiter_if.slave   bus
);

    localparam int            PTRW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNTW:0] DEPTH_CNT = (CNTW + 1)'(DEPTH);
    localparam logic [PTRW-1:0] PTR_ONE = PTRW'(1);

    // Buffer storage; live = occupied and not squashed
    logic [DEPTH-1:0]  ent_live_q, ent_live_d;
    logic [4:0]        ent_reg_q  [DEPTH];
    logic [4:0]        ent_reg_d  [DEPTH];
    logic [31:0]       ent_data_q [DEPTH];
    logic [31:0]       ent_data_d [DEPTH];
    logic [PTRW-1:0]   head_q, head_d;
    logic [PTRW-1:0]   tail_q, tail_d;
    logic [CNTW:0]     count_q, count_d;

    // Registered regfile write port
    logic              we_q, we_d;
    logic [4:0]        wreg_q, wreg_d;
    logic [31:0]       wdata_q, wdata_d;

    logic              w_md_ready;
    logic              w_md_acc;
    logic              w_pipe_sel;
    logic              w_empty;
    logic              w_pop;
    logic              w_bypass;
    logic              w_md_squash;
    logic              w_push;
    logic [31:0]       w_mask;

    // Per-cycle arbitration decisions
    always_comb begin
        w_md_ready  = (count_q < DEPTH_CNT) & ~ctrl_reset;
        w_md_acc    = bus.md_valid & w_md_ready;
        w_pipe_sel  = bus.pipe_valid & (bus.pipe_reg != 5'd0);
        w_empty     = (count_q == '0);
        w_pop       = ~w_pipe_sel & ~w_empty;
        w_bypass    = ~w_pipe_sel & w_empty & w_md_acc & (bus.md_reg != 5'd0);
        // An older md result to the register the pipe is writing is dead
        w_md_squash = w_pipe_sel & (bus.md_reg == bus.pipe_reg);
        w_push      = w_md_acc & (bus.md_reg != 5'd0) & ~w_bypass & ~w_md_squash;
    end

    // Next state for the buffer and the write port
    always_comb begin
        ent_live_d = ent_live_q;
        ent_reg_d  = ent_reg_q;
        ent_data_d = ent_data_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q + (CNTW + 1)'(w_push) - (CNTW + 1)'(w_pop);
        we_d       = 1'b0;
        wreg_d     = wreg_q;
        wdata_d    = wdata_q;

        if (w_pipe_sel) begin
            we_d    = 1'b1;
            wreg_d  = bus.pipe_reg;
            wdata_d = bus.pipe_data;
            // Squashed entries keep their slot but never reach the regfile
            for (int i = 0; i < DEPTH; i++) begin
                if (ent_reg_q[i] == bus.pipe_reg) begin
                    ent_live_d[i] = 1'b0;
                end
            end
        end else if (w_pop) begin
            we_d = ent_live_q[head_q];
            if (ent_live_q[head_q]) begin
                wreg_d  = ent_reg_q[head_q];
                wdata_d = ent_data_q[head_q];
            end
            ent_live_d[head_q] = 1'b0;
            head_d             = head_q + PTR_ONE;
        end else if (w_bypass) begin
            we_d    = 1'b1;
            wreg_d  = bus.md_reg;
            wdata_d = bus.md_data;
        end

        // Tail slot is never the popped slot: push is impossible when full
        if (w_push) begin
            ent_live_d[tail_q] = 1'b1;
            ent_reg_d[tail_q]  = bus.md_reg;
            ent_data_d[tail_q] = bus.md_data;
            tail_d             = tail_q + PTR_ONE;
        end
    end

    // State registers; reset flushes the buffer without writing it
    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            ent_live_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_reg_q[i]  <= 5'd0;
                ent_data_q[i] <= 32'd0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            we_q    <= 1'b0;
            wreg_q  <= 5'd0;
            wdata_q <= 32'd0;
        end else begin
            ent_live_q <= ent_live_d;
            ent_reg_q  <= ent_reg_d;
            ent_data_q <= ent_data_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            we_q       <= we_d;
            wreg_q     <= wreg_d;
            wdata_q    <= wdata_d;
        end
    end

    // Pending mask from live entries only; r0 is never pending
    always_comb begin
        w_mask = 32'd0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_live_q[i]) begin
                w_mask[ent_reg_q[i]] = 1'b1;
            end
        end
        w_mask[0] = 1'b0;
    end

    assign bus.md_ready         = w_md_ready;
    assign bus.ctrl_writeEnable = we_q;
    assign bus.ctrl_writeReg    = wreg_q;
    assign bus.data_writeReg    = wdata_q;
    assign bus.md_pending_mask  = w_mask;
    assign bus.md_count         = count_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_write_arbiter
//  Description : Directed bench for wb_write_arbiter. Expected regfile writes
//                are queued as stimulus is driven and retired in order as the
//                write port fires; status outputs are checked directly.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_write_arbiter;

    logic clock = 1'b0;
    logic ctrl_reset;

    wb_write_arbiter_if #(.CNTW(2)) bus ();

    wb_write_arbiter #(
        .DEPTH (2),
        .CNTW  (2)
    ) dut (
        .clock      (clock),
        .ctrl_reset (ctrl_reset),
        .bus        (bus)
    );

    always #5 clock = ~clock;

    int n_cmp  = 0;
    int n_fail = 0;

    // Expected writes in commit order: {reg, data}
    logic [36:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_pipe(input logic v, input logic [4:0] r, input logic [31:0] d);
        bus.pipe_valid = v;
        bus.pipe_reg   = r;
        bus.pipe_data  = d;
    endtask

    task automatic drive_md(input logic v, input logic [4:0] r, input logic [31:0] d);
        bus.md_valid = v;
        bus.md_reg   = r;
        bus.md_data  = d;
    endtask

    task automatic expect_write(input logic [4:0] r, input logic [31:0] d);
        exp_q.push_back({r, d});
    endtask

    // Retire one expected write for every cycle the write port fires
    always @(negedge clock) begin
        logic [36:0] e;
        if (bus.ctrl_writeEnable === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $error("FAIL unexpected_write: observed r%0d=%0h expected no write",
                       bus.ctrl_writeReg, bus.data_writeReg);
            end else begin
                e = exp_q.pop_front();
                n_cmp++;
                assert ({bus.ctrl_writeReg, bus.data_writeReg} === e) else begin
                    n_fail++;
                    $error("FAIL write_order: observed r%0d=%0h expected r%0d=%0h",
                           bus.ctrl_writeReg, bus.data_writeReg, e[36:32], e[31:0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset held with both sources active
        ctrl_reset = 1'b1;
        drive_pipe(1'b1, 5'd1, 32'h1111_1111);
        drive_md(1'b1, 5'd2, 32'h2222_2222);
        tick();
        tick();
        check("rst_we",    32'(bus.ctrl_writeEnable), 32'd0);
        check("rst_reg",   32'(bus.ctrl_writeReg),    32'd0);
        check("rst_data",  bus.data_writeReg,         32'd0);
        check("rst_ready", 32'(bus.md_ready),         32'd0);
        check("rst_count", 32'(bus.md_count),         32'd0);
        check("rst_mask",  bus.md_pending_mask,       32'd0);

        ctrl_reset = 1'b0;
        drive_pipe(1'b0, 5'd0, 32'd0);
        drive_md(1'b0, 5'd0, 32'd0);
        #1;
        check("post_rst_ready", 32'(bus.md_ready), 32'd1);
        check("post_rst_count", 32'(bus.md_count), 32'd0);

        // Pipe only
        drive_pipe(1'b1, 5'd5, 32'hDEAD_BEEF);
        expect_write(5'd5, 32'hDEAD_BEEF);
        tick();
        check("pipe_we",   32'(bus.ctrl_writeEnable), 32'd1);
        check("pipe_reg",  32'(bus.ctrl_writeReg),    32'd5);
        check("pipe_data", bus.data_writeReg,         32'hDEAD_BEEF);
        drive_pipe(1'b0, 5'd0, 32'd0);
        tick();
        check("pipe_idle_we",   32'(bus.ctrl_writeEnable), 32'd0);
        check("pipe_idle_hold", bus.data_writeReg,         32'hDEAD_BEEF);

        // Contention: pipe busy four cycles while md delivers three results
        drive_pipe(1'b1, 5'd3, 32'd1);
        drive_md(1'b1, 5'd10, 32'hA);
        expect_write(5'd3, 32'd1);
        tick();
        check("cont_count1", 32'(bus.md_count),   32'd1);
        check("cont_mask1",  bus.md_pending_mask, 32'h0000_0400);
        drive_pipe(1'b1, 5'd4, 32'd2);
        drive_md(1'b1, 5'd11, 32'hB);
        expect_write(5'd4, 32'd2);
        tick();
        check("cont_count2", 32'(bus.md_count),   32'd2);
        check("cont_mask2",  bus.md_pending_mask, 32'h0000_0C00);
        check("cont_full",   32'(bus.md_ready),   32'd0);
        drive_pipe(1'b1, 5'd6, 32'd3);
        drive_md(1'b1, 5'd12, 32'hC);
        expect_write(5'd6, 32'd3);
        tick();
        check("cont_block_count", 32'(bus.md_count), 32'd2);
        drive_pipe(1'b1, 5'd7, 32'd4);
        expect_write(5'd7, 32'd4);
        tick();
        check("cont_still_full", 32'(bus.md_ready), 32'd0);
        drive_pipe(1'b0, 5'd0, 32'd0);
        expect_write(5'd10, 32'hA);
        tick();
        check("cont_pop1_reg",   32'(bus.ctrl_writeReg), 32'd10);
        check("cont_pop1_count", 32'(bus.md_count),      32'd1);
        check("cont_pop1_ready", 32'(bus.md_ready),      32'd1);
        expect_write(5'd11, 32'hB);
        tick();
        drive_md(1'b0, 5'd0, 32'd0);
        check("cont_r12_count", 32'(bus.md_count),   32'd1);
        check("cont_r12_mask",  bus.md_pending_mask, 32'h0000_1000);
        expect_write(5'd12, 32'hC);
        tick();
        check("cont_drain_count", 32'(bus.md_count),   32'd0);
        check("cont_drain_mask",  bus.md_pending_mask, 32'd0);

        // Bypass into an idle port
        drive_md(1'b1, 5'd9, 32'h55);
        expect_write(5'd9, 32'h55);
        tick();
        check("byp_we",    32'(bus.ctrl_writeEnable), 32'd1);
        check("byp_count", 32'(bus.md_count),         32'd0);
        check("byp_mask",  bus.md_pending_mask,       32'd0);
        drive_md(1'b0, 5'd0, 32'd0);
        tick();
        check("byp_idle_we", 32'(bus.ctrl_writeEnable), 32'd0);

        // WAW squash of a buffered entry
        drive_pipe(1'b1, 5'd1, 32'h77);
        drive_md(1'b1, 5'd8, 32'h11);
        expect_write(5'd1, 32'h77);
        tick();
        check("waw_mask_set", bus.md_pending_mask, 32'h0000_0100);
        drive_md(1'b0, 5'd0, 32'd0);
        drive_pipe(1'b1, 5'd8, 32'h22);
        expect_write(5'd8, 32'h22);
        tick();
        check("waw_mask_clr", bus.md_pending_mask, 32'd0);
        check("waw_count",    32'(bus.md_count),   32'd1);
        drive_pipe(1'b0, 5'd0, 32'd0);
        tick();
        check("waw_pop_we",    32'(bus.ctrl_writeEnable), 32'd0);
        check("waw_pop_count", 32'(bus.md_count),         32'd0);
        check("waw_pop_hold",  bus.data_writeReg,         32'h22);

        // WAW squash of an md result arriving in the same cycle
        drive_pipe(1'b1, 5'd13, 32'h99);
        drive_md(1'b1, 5'd13, 32'h33);
        expect_write(5'd13, 32'h99);
        tick();
        check("waw_same_count", 32'(bus.md_count), 32'd0);
        drive_pipe(1'b0, 5'd0, 32'd0);
        drive_md(1'b0, 5'd0, 32'd0);
        tick();
        check("waw_same_idle_we", 32'(bus.ctrl_writeEnable), 32'd0);

        // Register zero from both sources
        drive_pipe(1'b1, 5'd0, 32'hFFFF_FFFF);
        drive_md(1'b1, 5'd0, 32'hEEEE_EEEE);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("zero_we",    32'(bus.ctrl_writeEnable), 32'd0);
            check("zero_count", 32'(bus.md_count),         32'd0);
            check("zero_ready", 32'(bus.md_ready),         32'd1);
        end

        // Reset mid-operation flushes buffered results
        drive_pipe(1'b1, 5'd2, 32'h1234);
        drive_md(1'b1, 5'd14, 32'h5678);
        expect_write(5'd2, 32'h1234);
        tick();
        check("flush_fill", 32'(bus.md_count), 32'd1);
        drive_pipe(1'b0, 5'd0, 32'd0);
        drive_md(1'b0, 5'd0, 32'd0);
        ctrl_reset = 1'b1;
        tick();
        check("flush_count", 32'(bus.md_count),   32'd0);
        check("flush_mask",  bus.md_pending_mask, 32'd0);
        ctrl_reset = 1'b0;
        tick();
        tick();
        check("flush_no_write", 32'(bus.ctrl_writeEnable), 32'd0);

        tick();
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
